// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types for the serial transmit path: arbiter FSM states, the number
// of requesters sharing the line, and the one-hot grant vector.
// No ports.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int NUM_UART_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } arb_state_t;

    typedef logic [NUM_UART_REQ-1:0] grant_t;

    // One-hot grant vector for requester index idx.
    function automatic grant_t req_onehot(input logic idx);
        grant_t g;
        g      = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter. A tx_start pulse seen while idle loads sdata and
// sends start bit, 8 data bits LSB first, and stop bit, each bit lasting
// 2*CLK_PER_HALF_BIT clocks. tx_busy is high from the edge that samples
// tx_start until the end of the stop-bit window. tx_start while busy is
// ignored.
// Ports:
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   sdata     in   byte to send, sampled with tx_start
//   tx_start  in   start request
//   tx_busy   out  frame in progress
//   txd       out  serial line, idles high
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sdata,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       txd
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [TW-1:0] TC_RELOAD = TW'(BIT_CYC - 1);

    // Frame shift register: bit 0 is the bit currently on the line. Ones are
    // shifted in behind the frame so the line rests at the stop level.
    logic [9:0]    shreg_q;
    logic [3:0]    bits_left_q;
    logic [TW-1:0] timer_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg_q     <= '1;
            bits_left_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
        end else if (!busy_q) begin
            if (tx_start) begin
                shreg_q     <= {1'b1, sdata, 1'b0};
                bits_left_q <= 4'd9;
                timer_q     <= TC_RELOAD;
                busy_q      <= 1'b1;
            end
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end else if (bits_left_q == '0) begin
            // Terminal count of the stop bit: frame complete.
            busy_q <= 1'b0;
        end else begin
            shreg_q     <= {1'b1, shreg_q[9:1]};
            bits_left_q <= bits_left_q - 1'b1;
            timer_q     <= TC_RELOAD;
        end
    end

    assign txd     = shreg_q[0];
    assign tx_busy = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter for two byte sources sharing one serial transmitter.
// One byte is accepted per frame; further grants are held until the frame's
// stop bit has completed.
//
// Optional feature macro: UART_TX_ARB_LOCK_EN
//   defined   : a byte accepted with reqN_lock=1 makes N the lock owner; only
//               the owner is eligible until it sends a byte with lock=0.
//   undefined : lock inputs ignored, pure per-byte round-robin.
//
// Ports:
//   clk                   in   system clock
//   rstn                  in   synchronous active-low reset
//   reqN_data[7:0]        in   byte from requester N
//   reqN_valid            in   requester N offers a byte
//   reqN_lock             in   keep grant after this byte (lock builds only)
//   reqN_ready            out  byte accepted when valid && ready
//   grant[1:0]            out  one-hot owner of the frame in flight
//   busy                  out  frame in flight (FSM not idle)
//   txd                   out  serial line
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_IDLE       | no frame in flight; arbitrate and accept one byte
// S_WAIT_BUSY  | start pulse issued, waiting for uart_tx to report busy
// S_WAIT_DONE  | frame on the line, waiting for uart_tx to go idle
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [7:0]              req0_data,
    input  logic                    req0_valid,
    input  logic                    req0_lock,
    output logic                    req0_ready,
    input  logic [7:0]              req1_data,
    input  logic                    req1_valid,
    input  logic                    req1_lock,
    output logic                    req1_ready,
    output logic [NUM_UART_REQ-1:0] grant,
    output logic                    busy,
    output logic                    txd
);

    arb_state_t state_q;
    grant_t     grant_q;
    logic       last_q;
    logic [7:0] sdata_r;
    logic       tx_start_q;
    logic       tx_busy;

    logic       elig0;
    logic       elig1;
    logic       sel;
    logic       sel_vld;
    logic [7:0] sel_data;
    logic       idle;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_act_q;
    logic lock_own_q;
    logic sel_lock;

    // A held lock shuts out the non-owner even when it is valid.
    assign elig0    = req0_valid && (!lock_act_q || (lock_own_q == 1'b0));
    assign elig1    = req1_valid && (!lock_act_q || (lock_own_q == 1'b1));
    assign sel_lock = sel ? req1_lock : req0_lock;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else if (idle && sel_vld) begin
            lock_act_q <= sel_lock;
            lock_own_q <= sel;
        end
    end
`else
    logic unused_lock;

    assign elig0       = req0_valid;
    assign elig1       = req1_valid;
    assign unused_lock = req0_lock | req1_lock;
`endif

    assign idle = (state_q == S_IDLE);

    // Both eligible: serve whoever was not served last.
    always_comb begin
        sel_vld = elig0 | elig1;
        sel     = 1'b0;
        if (elig0 && elig1) begin
            sel = ~last_q;
        end else begin
            sel = elig1;
        end
    end

    assign sel_data   = sel ? req1_data : req0_data;
    assign req0_ready = idle && sel_vld && (sel == 1'b0) && rstn;
    assign req1_ready = idle && sel_vld && (sel == 1'b1) && rstn;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= 1'b1;
            sdata_r    <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        sdata_r    <= sel_data;
                        grant_q    <= req_onehot(sel);
                        last_q     <= sel;
                        tx_start_q <= 1'b1;
                        state_q    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = !idle;

    uart_tx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rstn    (rstn),
        .sdata   (sdata_r),
        .tx_start(tx_start_q),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req0_lock, req0_ready;
    logic       req1_valid, req1_lock, req1_ready;
    logic [1:0] grant;
    logic       busy;
    logic       txd;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int cnt0    = 0;
    int cnt1    = 0;
    int viol    = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLK_PER_HALF_BIT(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_lock (req0_lock),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_lock (req1_lock),
        .req1_ready(req1_ready),
        .grant     (grant),
        .busy      (busy),
        .txd       (txd)
    );

    always @(posedge clk) begin
        if (rstn) begin
            if (req0_valid && req0_ready) cnt0 <= cnt0 + 1;
            if (req1_valid && req1_ready) cnt1 <= cnt1 + 1;
        end
    end

    always @(negedge clk) begin
        if ((busy && (req0_ready || req1_ready)) || (req0_ready && req1_ready))
            viol <= viol + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a start bit and samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int w;
        ok = 1'b1;
        b  = '0;
        w  = 0;
        @(negedge clk);
        while (txd !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (txd !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (4) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = txd;
        end
        repeat (8) @(negedge clk);
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] exp55;
        logic [7:0] rxb [8];
        logic       rxok [8];
        logic [7:0] lock_exp [4];
        logic [7:0] d0 [3];
        logic [2:0] l0;
        int         b0, b1, w;

        rstn = 1'b0;
        req0_data = 8'h00; req0_valid = 1'b1; req0_lock = 1'b0;
        req1_data = 8'h00; req1_valid = 1'b0; req1_lock = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_ready0_gated", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        req0_valid = 1'b0;

        // ---------------- single byte 0x55 ----------------
        @(negedge clk);
        req0_data = 8'h55; req0_valid = 1'b1;
        #1;
        chk("single_ready0", req0_ready, 1'b1);
        chk("single_ready1", req1_ready, 1'b0);
        chk("single_busy_pre", busy, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("single_busy", busy, 1'b1);
        chk("single_grant", grant, 2'b01);
        chk("single_ready0_off", req0_ready, 1'b0);
        exp55 = 8'h55;
        repeat (5) @(negedge clk);
        chk("single_start", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            chk($sformatf("single_bit%0d", i), txd, exp55[i]);
        end
        repeat (8) @(negedge clk);
        chk("single_stop", txd, 1'b1);
        repeat (4) @(negedge clk);
        chk("single_busy_last", busy, 1'b1);
        @(negedge clk);
        chk("single_busy_fall", busy, 1'b0);
        chk("single_grant_clr", grant, 2'b00);

        // ---------------- contention A0/B1, 4 each ----------------
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        b0 = cnt0; b1 = cnt1;
        req0_data = 8'hA0; req1_data = 8'hB1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("cont_first_ready0", req0_ready, 1'b1);
        chk("cont_first_ready1", req1_ready, 1'b0);
        fork
            begin
                for (int c = 0; c < 3000 && (req0_valid || req1_valid); c++) begin
                    @(negedge clk);
                    if (cnt0 - b0 >= 4) req0_valid = 1'b0;
                    if (cnt1 - b1 >= 4) req1_valid = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 8; k++) rx_byte(rxb[k], rxok[k]);
            end
        join
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cont_ok%0d", k), rxok[k], 1'b1);
            chk($sformatf("cont_byte%0d", k), rxb[k], (k % 2 == 0) ? 8'hA0 : 8'hB1);
        end
        chk("cont_cnt0", cnt0 - b0, 4);
        chk("cont_cnt1", cnt1 - b1, 4);
        wait_idle("cont_idle");

        // ---------------- back-pressure ----------------
        @(negedge clk);
        req0_data = 8'h3C; req0_valid = 1'b1;
        #1;
        chk("bp_ready0", req0_ready, 1'b1);
        fork
            begin
                for (int k = 0; k < 2; k++) rx_byte(rxb[k], rxok[k]);
            end
            begin
                @(negedge clk);
                req0_valid = 1'b0;
                repeat (20) @(negedge clk);
                req1_data = 8'hC3; req1_valid = 1'b1;
                #1;
                chk("bp_ready1_held", req1_ready, 1'b0);
                chk("bp_busy_mid", busy, 1'b1);
                w = 0;
                while (req1_ready !== 1'b1 && w < 300) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                chk("bp_ready1_served", req1_ready, 1'b1);
                chk("bp_busy_at_ready", busy, 1'b0);
                chk("bp_grant_at_ready", grant, 2'b00);
                @(negedge clk);
                req1_valid = 1'b0;
            end
        join
        chk("bp_ok0", rxok[0], 1'b1);
        chk("bp_byte0", rxb[0], 8'h3C);
        chk("bp_ok1", rxok[1], 1'b1);
        chk("bp_byte1", rxb[1], 8'hC3);
        wait_idle("bp_idle");

        // ---------------- lock sequence ----------------
        d0[0] = 8'h11; d0[1] = 8'h22; d0[2] = 8'h33;
        l0 = 3'b011;
`ifdef UART_TX_ARB_LOCK_EN
        lock_exp[0] = 8'h11; lock_exp[1] = 8'h22; lock_exp[2] = 8'h33; lock_exp[3] = 8'h44;
`else
        lock_exp[0] = 8'h11; lock_exp[1] = 8'h44; lock_exp[2] = 8'h22; lock_exp[3] = 8'h33;
`endif
        @(negedge clk);
        b0 = cnt0; b1 = cnt1;
        req0_data = d0[0]; req0_lock = l0[0]; req0_valid = 1'b1;
        req1_data = 8'h44; req1_valid = 1'b1;
        fork
            begin
                for (int c = 0; c < 3000 && (req0_valid || req1_valid); c++) begin
                    @(negedge clk);
                    if (cnt0 - b0 < 3) begin
                        req0_data = d0[cnt0 - b0];
                        req0_lock = l0[cnt0 - b0];
                    end else begin
                        req0_valid = 1'b0;
                        req0_lock  = 1'b0;
                    end
                    if (cnt1 - b1 >= 1) req1_valid = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 4; k++) rx_byte(rxb[k], rxok[k]);
            end
        join
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lock_ok%0d", k), rxok[k], 1'b1);
            chk($sformatf("lock_byte%0d", k), rxb[k], lock_exp[k]);
        end
        wait_idle("lock_idle");

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        req0_data = 8'h00; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (35) @(negedge clk);
        chk("midrst_txd_bit3", txd, 1'b0);
        chk("midrst_busy_pre", busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_grant", grant, 2'b00);
        rstn = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req1_data = 8'hA5;
        #1;
        chk("midrst_last_ready0", req0_ready, 1'b1);
        chk("midrst_last_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        #1;
        chk("midrst_ready1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("midrst_grant1", grant, 2'b10);
        rx_byte(rxb[0], rxok[0]);
        chk("midrst_ok", rxok[0], 1'b1);
        chk("midrst_byte", rxb[0], 8'hA5);
        wait_idle("midrst_idle");

        chk("ready_in_frame", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
